mul_seq_ctrl: RTL and testbench
===============================

// Module: mul_seq_ctrl
// PURPOSE
//   Multi-cycle shift-add multiplier sequencer built around one shared WIDTH-bit yAdder.
//   Sequences the adder once per cycle for WIDTH cycles to form a 2*WIDTH-bit product.
//   Serves as the HI/LO multiply unit beside the ALU in the MIPS datapath.
// PARAMETERS
//   WIDTH  32  operand width; product is 2*WIDTH bits
// PORTS
//   clk       in   1        rising-edge clock
//   reset     in   1        synchronous, active-high reset
//   start     in   1        request; sampled only in IDLE
//   a         in   WIDTH    multiplicand; latched when start is accepted
//   b         in   WIDTH    multiplier; latched when start is accepted
//   busy      out  1        high in every non-IDLE state
//   done      out  1        one-cycle pulse; product valid
//   prod_hi   out  WIDTH    upper half of product (MIPS HI)
//   prod_lo   out  WIDTH    lower half of product (MIPS LO)
// BEHAVIOUR
//   One clk. Reset is synchronous and active-high.
//   Reset: state=IDLE, busy=0, done=0, prod_hi=0, prod_lo=0, cnt=0. Reset mid-operation aborts the operation the same way.
//   FSM (unsigned): IDLE -start-> RUN -(cnt==WIDTH-1)-> DONE -> IDLE.
//   Accept edge E0 (IDLE and start): M<=a; {P_hi,P_lo}<={0,b}; cnt<=0.
//   RUN, each edge:
//     If P_lo[0]==1, yAdder(P_hi, M, cin=0) -> {cout, sum}.
//     Then {P_hi,P_lo} <= {cout, sum, P_lo} >> 1.
//     Otherwise {P_hi,P_lo} <= {1'b0, P_hi, P_lo} >> 1.
//     cnt++ on every RUN edge.
//   The adder carry-out is the bit shifted into P_hi[WIDTH-1]; no product bit is lost.
//   Latency: the RUN->DONE transition happens at edge E_WIDTH. done is high in the cycle after E_WIDTH only.
//   prod_hi/prod_lo: exposed P_hi/P_lo. They hold their value after DONE until the next accepted start.
//   start while busy: ignored, no queuing. start held high across DONE: re-accepted on the first IDLE cycle.
//   a and b may change freely after the accept edge.
//   cnt width is $clog2(WIDTH). It wraps only through the explicit reset to 0 on accept.
// CONFIGURATION
//   Macro MUL_SIGNED_EN.
//   Defined:
//     Adds input port is_signed (1 bit), latched with the operands.
//     FSM becomes IDLE -> NEG_A -> NEG_B -> RUN -> NEG_LO -> NEG_HI -> DONE.
//     NEG_A / NEG_B: if is_signed and the operand MSB is 1, the shared adder forms ~x + 1. Otherwise the operand passes through (x + 0).
//     NEG_LO / NEG_HI: if is_signed and the two sign bits differ, negate {P_hi,P_lo}.
//       NEG_LO computes ~P_lo + 1 and saves the carry.
//       NEG_HI computes ~P_hi + 0 + saved carry.
//     These states are always traversed, so latency is fixed at WIDTH+4 regardless of operand signs.
//     The adder is the only arithmetic resource; no extra incrementers.
//   Undefined: no is_signed port; unsigned FSM only; latency WIDTH.
// STRUCTURE
//   Shared include mul_defs.vh holds:
//     state encoding localparams (S_IDLE, S_NEG_A, S_NEG_B, S_RUN, S_NEG_LO, S_NEG_HI, S_DONE)
//     MUL_W default
//   Single sub-module: existing yAdder(z, cout, a, b, cin), one instance.
//   Its operand muxes are driven by the FSM.
//   Everything else (state register, counter, P/M registers) lives in this module.
// TESTING
//   1. a=3, b=5, start 1 cycle -> busy for 32 cycles; done at edge 33; prod_hi=0, prod_lo=15.
//   2. a=b=32'hFFFFFFFF -> prod_hi=32'hFFFFFFFE, prod_lo=32'h00000001 (checks carry-out shift-in).
//   3. Pulse start again mid-operation with a=7, b=7 -> ignored; the first result completes unchanged.
//   4. Assert reset at RUN cycle 10 -> next cycle busy=0, done=0, prod=0; a new start then works normally.
//   5. MUL_SIGNED_EN, is_signed=1:
//      a=-3, b=5 -> {hi,lo}=64'hFFFFFFFF_FFFFFFF1.
//      a=-3, b=-5 -> 15.
//      done at edge 37 in both cases.
//   6. Ten $random operand pairs, back-to-back starts -> {prod_hi,prod_lo} === a*b (64-bit); PASS/FAIL per pair.

Source files
------------

// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the shift-add multiply sequencer (MIPS HI/LO unit).
// State encoding covers both the unsigned-only and the signed (MUL_SIGNED_EN) flows.
package mul_seq_ctrl_pkg;

  // Default operand width; the product is twice this wide.
  localparam int MUL_W = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_NEG_A  = 3'd1,
    S_NEG_B  = 3'd2,
    S_RUN    = 3'd3,
    S_NEG_LO = 3'd4,
    S_NEG_HI = 3'd5,
    S_DONE   = 3'd6
  } mul_state_e;

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Request/result bundle for the multiply sequencer.
// Optional macro MUL_SIGNED_EN adds the is_signed request field.
interface mul_seq_ctrl_if
  import mul_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = MUL_W
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef MUL_SIGNED_EN
  logic             is_signed;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;

  // Requester side: issues operands, observes status and product.
  modport master (
`ifdef MUL_SIGNED_EN
    output is_signed,
`endif
    output start, a, b,
    input  busy, done, prod_hi, prod_lo
  );

  // Multiplier side.
  modport slave (
`ifdef MUL_SIGNED_EN
    input  is_signed,
`endif
    input  start, a, b,
    output busy, done, prod_hi, prod_lo
  );
endinterface

// File: rtl/mul_seq_ctrl_yadder.sv
// yAdder: the single WIDTH-bit ripple adder shared by every sequencer step.
module yAdder #(
  parameter int WIDTH = 32
) (
  output logic [WIDTH-1:0] z,
  output logic             cout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin
);

  // Full-width add with carry-in; carry-out is the extra top bit.
  always_comb begin
    {cout, z} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: multi-cycle shift-add multiplier that reuses one yAdder per cycle
// to build a 2*WIDTH-bit product in {P_hi,P_lo} (exposed as MIPS HI/LO).
// Optional macro MUL_SIGNED_EN: operands are sign-corrected before the run and
// the product is negated afterwards, all through the same adder.
module mul_seq_ctrl
  import mul_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = MUL_W
) (
  input  logic          clk,
  input  logic          reset,
  mul_seq_ctrl_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
`ifdef MUL_SIGNED_EN
  localparam mul_state_e FIRST_S = S_NEG_A;
  localparam mul_state_e AFTER_RUN_S = S_NEG_LO;
`else
  localparam mul_state_e FIRST_S = S_RUN;
  localparam mul_state_e AFTER_RUN_S = S_DONE;
`endif

  mul_state_e       state_r;
  mul_state_e       state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] p_hi_r;
  logic [WIDTH-1:0] p_lo_r;
  logic             busy_r;
  logic             done_r;
`ifdef MUL_SIGNED_EN
  logic             sa_r;     // multiplicand was negative (signed request)
  logic             sb_r;     // multiplier was negative (signed request)
  logic             carry_r;  // carry from the low-half negation
`endif

  logic [WIDTH-1:0] add_a_s;
  logic [WIDTH-1:0] add_b_s;
  logic             add_cin_s;
  logic [WIDTH-1:0] add_sum_s;
  logic             add_co_s;

  yAdder #(.WIDTH(WIDTH)) u_adder (
    .z    (add_sum_s),
    .cout (add_co_s),
    .a    (add_a_s),
    .b    (add_b_s),
    .cin  (add_cin_s)
  );

  // Next-state selection for the sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) state_nx_s = FIRST_S;
        else           state_nx_s = S_IDLE;
      end
      S_RUN: begin
        if (cnt_r == CNT_LAST) state_nx_s = AFTER_RUN_S;
        else                   state_nx_s = S_RUN;
      end
`ifdef MUL_SIGNED_EN
      S_NEG_A:  state_nx_s = S_NEG_B;
      S_NEG_B:  state_nx_s = S_RUN;
      S_NEG_LO: state_nx_s = S_NEG_HI;
      S_NEG_HI: state_nx_s = S_DONE;
`endif
      S_DONE:   state_nx_s = S_IDLE;
      default:  state_nx_s = S_IDLE;
    endcase
  end

  // Adder operand muxes; RUN accumulates M into P_hi, NEG steps form ~x + cin.
  always_comb begin
    add_a_s   = p_hi_r;
    add_b_s   = m_r;
    add_cin_s = 1'b0;
    case (state_r)
      S_RUN: begin
        add_a_s   = p_hi_r;
        add_b_s   = m_r;
        add_cin_s = 1'b0;
      end
`ifdef MUL_SIGNED_EN
      S_NEG_A: begin
        add_a_s   = sa_r ? ~m_r : m_r;
        add_b_s   = '0;
        add_cin_s = sa_r;
      end
      S_NEG_B: begin
        add_a_s   = sb_r ? ~p_lo_r : p_lo_r;
        add_b_s   = '0;
        add_cin_s = sb_r;
      end
      S_NEG_LO: begin
        add_a_s   = (sa_r ^ sb_r) ? ~p_lo_r : p_lo_r;
        add_b_s   = '0;
        add_cin_s = sa_r ^ sb_r;
      end
      S_NEG_HI: begin
        add_a_s   = (sa_r ^ sb_r) ? ~p_hi_r : p_hi_r;
        add_b_s   = '0;
        add_cin_s = (sa_r ^ sb_r) ? carry_r : 1'b0;
      end
`endif
      default: begin
        add_a_s   = p_hi_r;
        add_b_s   = m_r;
        add_cin_s = 1'b0;
      end
    endcase
  end

  // State, counter, operand/product registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      m_r     <= '0;
      p_hi_r  <= '0;
      p_lo_r  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef MUL_SIGNED_EN
      sa_r    <= 1'b0;
      sb_r    <= 1'b0;
      carry_r <= 1'b0;
`endif
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s != S_IDLE);
      done_r  <= (state_nx_s == S_DONE);
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            m_r    <= bus.a;
            p_hi_r <= '0;
            p_lo_r <= bus.b;
            cnt_r  <= '0;
`ifdef MUL_SIGNED_EN
            sa_r   <= bus.is_signed & bus.a[WIDTH-1];
            sb_r   <= bus.is_signed & bus.b[WIDTH-1];
`endif
          end
        end
        S_RUN: begin
          // Carry-out becomes the new P_hi MSB, so no product bit is dropped.
          if (p_lo_r[0]) begin
            p_hi_r <= {add_co_s, add_sum_s[WIDTH-1:1]};
            p_lo_r <= {add_sum_s[0], p_lo_r[WIDTH-1:1]};
          end else begin
            p_hi_r <= {1'b0, p_hi_r[WIDTH-1:1]};
            p_lo_r <= {p_hi_r[0], p_lo_r[WIDTH-1:1]};
          end
          // Counter parks at its last value; accept is the only way back to 0.
          if (cnt_r != CNT_LAST) cnt_r <= cnt_r + CNT_W'(1);
        end
`ifdef MUL_SIGNED_EN
        S_NEG_A:  m_r    <= add_sum_s;
        S_NEG_B:  p_lo_r <= add_sum_s;
        S_NEG_LO: begin
          p_lo_r  <= add_sum_s;
          carry_r <= add_co_s;
        end
        S_NEG_HI: p_hi_r <= add_sum_s;
`endif
        default: begin
          m_r <= m_r;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.prod_hi = p_hi_r;
  assign bus.prod_lo = p_lo_r;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl; covers MUL_SIGNED_EN when that macro is defined.
`timescale 1ns/1ps
module tb_mul_seq_ctrl;
  import mul_seq_ctrl_pkg::*;

  localparam int W = 32;
`ifdef MUL_SIGNED_EN
  localparam int LAT = W + 4;
`else
  localparam int LAT = W;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl_if #(.WIDTH(W)) bus ();
  mul_seq_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 200 && bus.busy; i++) tick();
    if (bus.busy) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle: busy still %b, required 0", bus.busy);
    end
  endtask

  // One request from idle; returns product, edges-to-done and busy dropouts.
  task automatic run_mul(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sg,
                         output logic [2*W-1:0] prod, output int lat, output int gaps);
    wait_idle();
    bus.a = av;
    bus.b = bv;
`ifdef MUL_SIGNED_EN
    bus.is_signed = sg;
`endif
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a = ~av;
    bus.b = ~bv;
    lat = 0;
    gaps = 0;
    while (!bus.done && lat < 200) begin
      if (!bus.busy) gaps++;
      tick();
      lat++;
    end
    prod = {bus.prod_hi, bus.prod_lo};
    if (sg) gaps = gaps + 0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.a = 32'd0;
    bus.b = 32'd0;
`ifdef MUL_SIGNED_EN
    bus.is_signed = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_vec++; if ({bus.prod_hi, bus.prod_lo} !== 64'd0) begin n_err++; $display("FAIL reset_prod: got %h want 0", {bus.prod_hi, bus.prod_lo}); end
  endtask

  task automatic test_basic;
    logic [2*W-1:0] p;
    int lat, gaps;
    run_mul(32'd3, 32'd5, 1'b0, p, lat, gaps);
    n_vec++; if (p !== 64'd15) begin n_err++; $display("FAIL basic_prod: got %h want %h", p, 64'd15); end
    n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
    n_vec++; if (gaps !== 0) begin n_err++; $display("FAIL basic_busy_gap: got %0d want 0", gaps); end
    tick();
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b want 0", bus.done); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL basic_idle_busy: got %b want 0", bus.busy); end
    tick();
    n_vec++; if ({bus.prod_hi, bus.prod_lo} !== 64'd15) begin n_err++; $display("FAIL basic_hold: got %h want %h", {bus.prod_hi, bus.prod_lo}, 64'd15); end
  endtask

  task automatic test_carry;
    logic [2*W-1:0] p;
    int lat, gaps;
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, p, lat, gaps);
    n_vec++; if (p !== 64'hFFFFFFFE_00000001) begin n_err++; $display("FAIL carry_prod: got %h want %h", p, 64'hFFFFFFFE_00000001); end
    n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL carry_latency: got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_ignore_start;
    int lat;
    wait_idle();
    bus.a = 32'd1000;
    bus.b = 32'd1000;
`ifdef MUL_SIGNED_EN
    bus.is_signed = 1'b0;
`endif
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 0;
    for (int i = 0; i < 4; i++) begin tick(); lat++; end
    bus.a = 32'd7;
    bus.b = 32'd7;
    bus.start = 1'b1;
    tick();
    lat++;
    bus.start = 1'b0;
    while (!bus.done && lat < 200) begin tick(); lat++; end
    n_vec++; if ({bus.prod_hi, bus.prod_lo} !== 64'd1000000) begin n_err++; $display("FAIL ignore_prod: got %h want %h", {bus.prod_hi, bus.prod_lo}, 64'd1000000); end
    n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL ignore_latency: got %0d want %0d", lat, LAT); end
    tick();
    tick();
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL ignore_no_queue: busy %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid;
    logic [2*W-1:0] p;
    int lat, gaps;
    wait_idle();
    bus.a = 32'd9;
    bus.b = 32'd9;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL midreset_done: got %b want 0", bus.done); end
    n_vec++; if ({bus.prod_hi, bus.prod_lo} !== 64'd0) begin n_err++; $display("FAIL midreset_prod: got %h want 0", {bus.prod_hi, bus.prod_lo}); end
    run_mul(32'd6, 32'd7, 1'b0, p, lat, gaps);
    n_vec++; if (p !== 64'd42) begin n_err++; $display("FAIL midreset_restart: got %h want %h", p, 64'd42); end
    n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL midreset_latency: got %0d want %0d", lat, LAT); end
  endtask

`ifdef MUL_SIGNED_EN
  task automatic test_signed;
    logic [2*W-1:0] p;
    int lat, gaps;
    run_mul(32'hFFFFFFFD, 32'd5, 1'b1, p, lat, gaps);
    n_vec++; if (p !== 64'hFFFFFFFF_FFFFFFF1) begin n_err++; $display("FAIL signed_neg_pos: got %h want %h", p, 64'hFFFFFFFF_FFFFFFF1); end
    n_vec++; if (lat !== W + 4) begin n_err++; $display("FAIL signed_latency1: got %0d want %0d", lat, W + 4); end
    run_mul(32'hFFFFFFFD, 32'hFFFFFFFB, 1'b1, p, lat, gaps);
    n_vec++; if (p !== 64'd15) begin n_err++; $display("FAIL signed_neg_neg: got %h want %h", p, 64'd15); end
    n_vec++; if (lat !== W + 4) begin n_err++; $display("FAIL signed_latency2: got %0d want %0d", lat, W + 4); end
    run_mul(32'hFFFFFFFD, 32'd0, 1'b1, p, lat, gaps);
    n_vec++; if (p !== 64'd0) begin n_err++; $display("FAIL signed_zero: got %h want 0", p); end
  endtask
`endif

  // start held high: each product completes, one idle cycle, then re-accept.
  task automatic test_back_to_back;
    logic [W-1:0] av [10];
    logic [W-1:0] bv [10];
    logic [2*W-1:0] exp_p;
    int k;
    av[0] = 32'h80000000;
    bv[0] = 32'h00000002;
    for (int i = 1; i < 10; i++) begin
      av[i] = $urandom;
      bv[i] = $urandom;
    end
    wait_idle();
`ifdef MUL_SIGNED_EN
    bus.is_signed = 1'b0;
`endif
    bus.a = av[0];
    bus.b = bv[0];
    bus.start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      k = 0;
      do begin
        tick();
        k++;
      end while (!bus.done && k < 200);
      exp_p = {32'd0, av[i]} * {32'd0, bv[i]};
      n_vec++; if ({bus.prod_hi, bus.prod_lo} !== exp_p) begin n_err++; $display("FAIL b2b_prod[%0d]: got %h want %h", i, {bus.prod_hi, bus.prod_lo}, exp_p); end
      n_vec++; if (k !== LAT + 1) begin n_err++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, k, LAT + 1); end
      if (i < 9) begin
        bus.a = av[i+1];
        bus.b = bv[i+1];
      end else begin
        bus.start = 1'b0;
      end
      tick();
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle[%0d]: busy %b want 0", i, bus.busy); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_reset_mid();
`ifdef MUL_SIGNED_EN
    test_signed();
`endif
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
